// File: rtl/mul_issue_seq_if.sv
// Request/issue/result bundle for mul_issue_seq.
// slave: the sequencer. master: the requester / writeback side.
interface mul_issue_seq_if #(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned BeatW = 1
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sew;
  logic [VLEN-1:0]   req_vs1;
  logic [VLEN-1:0]   req_vs2;
  logic              flush;
  logic [1:0]        mul_sew;
  logic              mul_count_0;
  logic              mul_start;
  logic [31:0]       mul_A1;
  logic [31:0]       mul_B1;
  logic [31:0]       mul_A2;
  logic [31:0]       mul_B2;
  logic              res_valid;
  logic [BeatW-1:0]  res_beat;
  logic              res_last;
  logic              busy;
  logic              err;

  modport slave (
    input  req_valid, req_sew, req_vs1, req_vs2, flush,
    output req_ready, mul_sew, mul_count_0, mul_start, mul_A1, mul_B1, mul_A2, mul_B2,
    output res_valid, res_beat, res_last, busy, err
  );

  modport master (
    output req_valid, req_sew, req_vs1, req_vs2, flush,
    input  req_ready, mul_sew, mul_count_0, mul_start, mul_A1, mul_B1, mul_A2, mul_B2,
    input  res_valid, res_beat, res_last, busy, err
  );
endinterface

// File: rtl/mul_issue_seq.sv
// mul_issue_seq: slices one VLEN-bit vector multiply request into 64-bit beats for the
// 8-bit-slice multiplier and strobes each beat's products LAT cycles after it issues.
// Optional feature: define MUL_ISSUE_SEQ_OVERLAP_EN to accept the next request while the
// previous one is still draining.
module mul_issue_seq #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned LAT  = 3
) (
  input  logic           clk,
  input  logic           reset,
  mul_issue_seq_if.slave bus
);
  localparam int unsigned NB  = VLEN / 64;
  localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned PW  = BW + 2;
  localparam int unsigned Top = LAT - 1;
  localparam logic [BW-1:0] LastBeat  = BW'(NB - 1);
  localparam logic [CW-1:0] DrainInit = CW'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            sub_q, sub_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VLEN-1:0] vs1_q, vs1_d, vs2_q, vs2_d;
  logic [1:0]      sew_q, sew_d;
  logic            err_q, err_d;
  logic            alive_q;
  logic [31:0]     a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
  logic            start_q, start_d;
  // Completion pipe entry: {valid, beat, last}
  logic [PW-1:0]   pipe_q [LAT];
  logic [PW-1:0]   pipe_d [LAT];

  logic ready_state, req_ready, hs, sew_ok, last_sub, fin, issue_d;

`ifdef MUL_ISSUE_SEQ_OVERLAP_EN
  assign ready_state = (state_q == StIdle) || (state_q == StDrain);
`else
  assign ready_state = (state_q == StIdle);
`endif

  // alive_q keeps req_ready low until the first edge after reset release
  assign req_ready = alive_q && ready_state && !bus.flush;
  assign hs        = bus.req_valid && req_ready;
  assign sew_ok    = (bus.req_sew != 2'b11);
  assign last_sub  = (sew_q == 2'b10);
  assign fin       = (state_q == StIssue) && (sub_q == last_sub) && !bus.flush;

  // Next state: beat/sub sequencing, drain countdown, request capture, flush override
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    sew_d   = sew_q;
    err_d   = 1'b0;
    case (state_q)
      StIssue: begin
        if (sub_q != last_sub) begin
          sub_d = 1'b1;
        end else begin
          sub_d = 1'b0;
          if (beat_q == LastBeat) begin
            state_d = StDrain;
            cnt_d   = DrainInit;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: ;
    endcase
    if (hs) begin
      // An illegal sew is rejected without disturbing the captured sew or operands
      if (sew_ok) begin
        vs1_d   = bus.req_vs1;
        vs2_d   = bus.req_vs2;
        sew_d   = bus.req_sew;
        state_d = StIssue;
        beat_d  = '0;
        sub_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (bus.flush) state_d = StIdle;
  end

  // Registered multiplier drive, computed from the next state
  always_comb begin
    issue_d = (state_d == StIssue);
    a1_d    = issue_d ? vs1_d[{beat_d, 6'd0}  +: 32] : '0;
    a2_d    = issue_d ? vs1_d[{beat_d, 6'd32} +: 32] : '0;
    b1_d    = issue_d ? vs2_d[{beat_d, 6'd0}  +: 32] : '0;
    b2_d    = issue_d ? vs2_d[{beat_d, 6'd32} +: 32] : '0;
    start_d = issue_d && (sub_d == 1'b0);
  end

  // Completion pipe: load on a beat's final issue cycle, cleared by flush
  always_comb begin
    pipe_d[0] = fin ? {1'b1, beat_q, (beat_q == LastBeat)} : '0;
    for (int i = 1; i < int'(LAT); i++) pipe_d[i] = pipe_q[i-1];
    if (bus.flush) begin
      for (int i = 0; i < int'(LAT); i++) pipe_d[i] = '0;
    end
  end

  // All sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      sew_q   <= 2'b00;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      sew_q   <= sew_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      start_q <= start_d;
      for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.mul_sew     = sew_q;
  // count_0 and start coincide: both mark the first cycle of a beat
  assign bus.mul_count_0 = start_q;
  assign bus.mul_start   = start_q;
  assign bus.mul_A1      = a1_q;
  assign bus.mul_A2      = a2_q;
  assign bus.mul_B1      = b1_q;
  assign bus.mul_B2      = b2_q;
  assign bus.res_valid   = pipe_q[Top][PW-1];
  assign bus.res_beat    = pipe_q[Top][PW-2:1];
  assign bus.res_last    = pipe_q[Top][0];
  assign bus.busy        = (state_q != StIdle);
  assign bus.err         = err_q;
endmodule

// File: tb/tb_mul_issue_seq.sv
// Bench for mul_issue_seq: each accepted request is expanded into an expected
// cycle-by-cycle timeline (issue slots, result strobes, busy window), then every
// output is compared against that timeline each cycle.
module tb_mul_issue_seq;
  localparam int unsigned VLEN = 128;
  localparam int unsigned LAT  = 3;
  localparam int unsigned NB   = VLEN / 64;
  localparam int unsigned BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int          MAXC = 4096;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   alive_from = 1 << 30;

  mul_issue_seq_if #(.VLEN(VLEN), .BeatW(BW)) bus ();
  mul_issue_seq #(.VLEN(VLEN), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Expected timeline, indexed by cycle number
  logic [31:0]   e_a1 [MAXC];
  logic [31:0]   e_a2 [MAXC];
  logic [31:0]   e_b1 [MAXC];
  logic [31:0]   e_b2 [MAXC];
  logic          e_st [MAXC];
  logic          e_busy [MAXC];
  logic          e_drain [MAXC];
  logic          e_rv [MAXC];
  logic          e_rl [MAXC];
  logic [BW-1:0] e_rb [MAXC];
  logic          e_err [MAXC];
  logic [1:0]    e_sew [MAXC];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Drop everything in flight from cycle t0 on (flush / reset)
  function automatic void cancel(input int t0, input bit full);
    for (int t = t0; t < MAXC; t++) begin
      e_a1[t] = '0; e_a2[t] = '0; e_b1[t] = '0; e_b2[t] = '0;
      e_st[t] = 1'b0; e_busy[t] = 1'b0; e_drain[t] = 1'b0;
      e_rv[t] = 1'b0; e_rl[t] = 1'b0; e_rb[t] = '0;
      if (full) begin
        e_err[t] = 1'b0;
        e_sew[t] = 2'b00;
      end
    end
  endfunction

  // Request accepted in cycle c: lay out its issue slots, result strobes and busy window
  function automatic void schedule(input int c, input logic [1:0] sew,
                                   input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    int cpb, t, e;
    if (sew == 2'b11) begin
      e_err[c+1] = 1'b1;
      return;
    end
    cpb = (sew == 2'b10) ? 2 : 1;
    for (t = c + 1; t < MAXC; t++) begin
      e_sew[t]   = sew;
      e_drain[t] = 1'b0;
    end
    for (int k = 0; k < int'(NB); k++) begin
      for (int s = 0; s < cpb; s++) begin
        t = c + 1 + k * cpb + s;
        e_a1[t] = a[64*k +: 32];
        e_a2[t] = a[64*k+32 +: 32];
        e_b1[t] = b[64*k +: 32];
        e_b2[t] = b[64*k+32 +: 32];
        e_st[t] = (s == 0);
        e_busy[t] = 1'b1;
      end
      t = c + (k + 1) * cpb + int'(LAT);
      e_rv[t] = 1'b1;
      e_rb[t] = BW'(k);
      e_rl[t] = (k == int'(NB) - 1);
    end
    e = c + int'(NB) * cpb;
    for (int d = 1; d <= int'(LAT); d++) begin
      e_busy[e+d]  = 1'b1;
      e_drain[e+d] = 1'b1;
    end
  endfunction

  function automatic logic model_ready(input int t, input logic fl);
    logic st_ok;
    st_ok = !e_busy[t];
`ifdef MUL_ISSUE_SEQ_OVERLAP_EN
    st_ok = st_ok || e_drain[t];
`endif
    return (t >= alive_from) && !fl && st_ok;
  endfunction

  task automatic check_all(input int t, input logic rdy);
    check_eq("req_ready", 64'(bus.req_ready), 64'(rdy));
    check_eq("busy", 64'(bus.busy), 64'(e_busy[t]));
    check_eq("err", 64'(bus.err), 64'(e_err[t]));
    check_eq("mul_start", 64'(bus.mul_start), 64'(e_st[t]));
    check_eq("mul_count_0", 64'(bus.mul_count_0), 64'(e_st[t]));
    check_eq("mul_sew", 64'(bus.mul_sew), 64'(e_sew[t]));
    check_eq("mul_A1", 64'(bus.mul_A1), 64'(e_a1[t]));
    check_eq("mul_A2", 64'(bus.mul_A2), 64'(e_a2[t]));
    check_eq("mul_B1", 64'(bus.mul_B1), 64'(e_b1[t]));
    check_eq("mul_B2", 64'(bus.mul_B2), 64'(e_b2[t]));
    check_eq("res_valid", 64'(bus.res_valid), 64'(e_rv[t]));
    if (e_rv[t]) begin
      check_eq("res_beat", 64'(bus.res_beat), 64'(e_rb[t]));
      check_eq("res_last", 64'(bus.res_last), 64'(e_rl[t]));
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model
  task automatic step(input logic v, input logic [1:0] sew, input logic [VLEN-1:0] a,
                      input logic [VLEN-1:0] b, input logic fl, output logic acc);
    logic rdy;
    @(posedge clk);
    cyc++;
    #1;
    bus.req_valid = v;
    bus.req_sew   = sew;
    bus.req_vs1   = a;
    bus.req_vs2   = b;
    bus.flush     = fl;
    #1;
    rdy = model_ready(cyc, fl);
    check_all(cyc, rdy);
    acc = v && rdy;
    if (acc) schedule(cyc, sew, a, b);
    if (fl) cancel(cyc + 1, 1'b0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, 1'b0, acc);
  endtask

  // Hold a request until the model accepts it, bounded
  task automatic send(input logic [1:0] sew, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      step(1'b1, sew, a, b, 1'b0, acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", 64'(n), 64'(0));
  endtask

  // Async reset asserted mid-cycle: outputs must clear immediately
  task automatic mid_reset();
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_ready", 64'(bus.req_ready), 64'(0));
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_start", 64'(bus.mul_start), 64'(0));
    check_eq("rst_a1", 64'(bus.mul_A1), 64'(0));
    check_eq("rst_res_valid", 64'(bus.res_valid), 64'(0));
    cancel(cyc + 1, 1'b1);
    alive_from = 1 << 30;
    idle(2);
    reset      = 1'b1;
    alive_from = cyc + 1;
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < int'(VLEN / 32); i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [VLEN-1:0] va, vb;
    logic [1:0]      sw;
    logic            acc;

    cancel(0, 1'b1);
    bus.req_valid = 1'b0;
    bus.req_sew   = 2'b00;
    bus.req_vs1   = '0;
    bus.req_vs2   = '0;
    bus.flush     = 1'b0;

    // Power-on reset
    idle(3);
    reset      = 1'b1;
    alive_from = cyc + 1;
    idle(2);

    va = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    vb = {4{32'h02020202}};

    // sew=8, then spot-check the first issued beat
    send(2'b00, va, vb);
    idle(1);
    check_eq("tp_a1", 64'(bus.mul_A1), 64'h04030201);
    check_eq("tp_b1", 64'(bus.mul_B1), 64'h02020202);
    idle(8);

    // sew=32: two cycles per beat
    send(2'b10, va, vb);
    idle(10);

    // Illegal sew
    send(2'b11, va, vb);
    idle(3);

    // Flush two cycles into a sew=16 request, then a new request right after
    send(2'b01, va, vb);
    step(1'b0, 2'b00, '0, '0, 1'b0, acc);
    step(1'b0, 2'b00, '0, '0, 1'b1, acc);
    send(2'b00, vb, va);
    idle(8);

    // Reset in the middle of issue
    send(2'b10, va, vb);
    idle(2);
    mid_reset();
    send(2'b01, va, vb);
    idle(8);

    // Second request offered during the first one's drain
    send(2'b00, va, vb);
    idle(2);
    send(2'b01, vb, va);
    idle(10);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      sw = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(($urandom_range(0, 2) != 0), sw, rand_vec(), rand_vec(),
           ($urandom_range(0, 39) == 0), acc);
      if ($urandom_range(0, 299) == 0) mid_reset();
      if (cyc > MAXC - 64) break;
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
